// File: rtl/wave_pkg.sv
// Shared types and constants for the waveform test path (monitor and sine generator).
package wave_pkg;

    localparam int SAMPLE_W         = 8;
    localparam int MIDSCALE_DEFAULT = 128;
    localparam int HYST_DEFAULT     = 8;

    typedef logic [SAMPLE_W-1:0] sample_t;

    typedef enum logic {
        S_ACQ = 1'b0,
        S_RUN = 1'b1
    } state_t;

endpackage

// File: rtl/wave_monitor_hyst_region.sv
// Hysteresis region tracker: flags the accepted sample that moves the region from LO to HI.
module hyst_region
    import wave_pkg::*;
#(
    parameter int MIDSCALE = MIDSCALE_DEFAULT,
    parameter int HYST     = HYST_DEFAULT
) (
    input  logic    clk,
    input  logic    rst,
    input  sample_t sample,
    input  logic    sample_valid,
    output logic    edge_det
);

    localparam sample_t LO_TH = sample_t'(MIDSCALE - HYST);
    localparam sample_t HI_TH = sample_t'(MIDSCALE + HYST);

    logic region_hi;
    logic is_lo;
    logic is_hi;

    assign is_lo    = (sample < LO_TH);
    assign is_hi    = (sample >= HI_TH);
    assign edge_det = sample_valid && !region_hi && is_hi;

    // Region resets to HI so a LO excursion must be seen before the first edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            region_hi <= 1'b1;
        end else if (sample_valid) begin
            if (is_lo) begin
                region_hi <= 1'b0;
            end else if (is_hi) begin
                region_hi <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/wave_monitor.sv
// Per-cycle period / peak / amplitude measurement of an 8-bit sample stream.
// Handshake: a sample is consumed on every clock with sample_valid=1; there is no backpressure.
module wave_monitor
    import wave_pkg::*;
#(
    parameter int MIDSCALE = MIDSCALE_DEFAULT,
    parameter int HYST     = HYST_DEFAULT,
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  sample_t             sample_in,
    input  logic                sample_valid,
    output logic [PERIOD_W-1:0] period,
    output sample_t             peak_max,
    output sample_t             peak_min,
    output sample_t             amplitude,
    output logic                meas_valid,
    output logic                timeout,
    output logic                locked,
    output state_t              state_dbg
);

    // Last count value a non-edge sample may find before the window overflows.
    localparam logic [PERIOD_W-1:0] CNT_LAST = {{(PERIOD_W-1){1'b1}}, 1'b0};

    state_t              state;
    logic [PERIOD_W-1:0] cnt;
    sample_t             run_min;
    sample_t             run_max;
    sample_t             win_min;
    sample_t             win_max;
    logic                edge_det;

    hyst_region #(
        .MIDSCALE (MIDSCALE),
        .HYST     (HYST)
    ) u_region (
        .clk          (clk),
        .rst          (rst),
        .sample       (sample_in),
        .sample_valid (sample_valid),
        .edge_det     (edge_det)
    );

    // Window extremes including the sample currently presented.
    always_comb begin
        win_max = (sample_in > run_max) ? sample_in : run_max;
        win_min = (sample_in < run_min) ? sample_in : run_min;
    end

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_ACQ;
            cnt        <= '0;
            run_min    <= '1;
            run_max    <= '0;
            period     <= '0;
            peak_max   <= '0;
            peak_min   <= '0;
            amplitude  <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            locked     <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            if (sample_valid) begin
                case (state)
                    S_ACQ: begin
                        if (edge_det) begin
                            state   <= S_RUN;
                            cnt     <= '0;
                            run_min <= '1;
                            run_max <= '0;
                        end
                    end
                    S_RUN: begin
                        if (edge_det) begin
                            period     <= cnt + 1'b1;
                            peak_max   <= win_max;
                            peak_min   <= win_min;
                            amplitude  <= win_max - win_min;
                            meas_valid <= 1'b1;
                            locked     <= 1'b1;
                            cnt        <= '0;
                            run_min    <= '1;
                            run_max    <= '0;
                        end else if (cnt == CNT_LAST) begin
                            // Results are kept; only lock is dropped.
                            timeout <= 1'b1;
                            locked  <= 1'b0;
                            state   <= S_ACQ;
                        end else begin
                            cnt     <= cnt + 1'b1;
                            run_min <= win_min;
                            run_max <= win_max;
                        end
                    end
                    default: state <= S_ACQ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wave_monitor.sv
// Bench for wave_monitor: a default instance and a PERIOD_W=4 instance share one stimulus stream.
module tb_wave_monitor;
    import wave_pkg::*;

    logic    clk = 1'b0;
    logic    rst = 1'b1;
    sample_t sample_in = '0;
    logic    sample_valid = 1'b0;

    logic [15:0] p0;
    sample_t     mx0, mn0, amp0;
    logic        mv0, to0, lk0;
    state_t      st0;

    logic [3:0]  p1;
    sample_t     mx1, mn1, amp1;
    logic        mv1, to1, lk1;
    state_t      st1;

    always #5 clk = ~clk;

    wave_monitor #(.PERIOD_W(16)) dut (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .period(p0), .peak_max(mx0), .peak_min(mn0), .amplitude(amp0),
        .meas_valid(mv0), .timeout(to0), .locked(lk0), .state_dbg(st0)
    );

    wave_monitor #(.PERIOD_W(4)) dut_short (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .period(p1), .peak_max(mx1), .peak_min(mn1), .amplitude(amp1),
        .meas_valid(mv1), .timeout(to1), .locked(lk1), .state_dbg(st1)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a window is the run of accepted samples after the last edge.
    int hist[$];
    bit m_region_hi;
    int pw_of[2] = '{16, 4};
    bit m_run[2];
    int win_start[2];
    int e_period[2], e_max[2], e_min[2], e_amp[2];
    bit e_mv[2], e_to[2], e_lk[2];

    task automatic model_reset();
        m_region_hi = 1'b1;
        hist.delete();
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 1'b0; win_start[i] = 0;
            e_period[i] = 0; e_max[i] = 0; e_min[i] = 0; e_amp[i] = 0;
            e_mv[i] = 1'b0; e_to[i] = 1'b0; e_lk[i] = 1'b0;
        end
    endtask

    task automatic model_clock(input bit r, input bit v, input int s);
        bit is_edge;
        int idx, n, hi, lo;
        if (r) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            e_mv[i] = 1'b0; e_to[i] = 1'b0;
        end
        if (!v) return;
        is_edge = !m_region_hi && (s >= 136);
        if (s < 120) m_region_hi = 1'b0;
        else if (s >= 136) m_region_hi = 1'b1;
        hist.push_back(s);
        idx = hist.size() - 1;
        for (int i = 0; i < 2; i++) begin
            if (!m_run[i]) begin
                if (is_edge) begin
                    m_run[i] = 1'b1; win_start[i] = idx;
                end
            end else begin
                n = idx - win_start[i];
                if (is_edge) begin
                    hi = 0; lo = 255;
                    for (int k = win_start[i] + 1; k <= idx; k++) begin
                        if (hist[k] > hi) hi = hist[k];
                        if (hist[k] < lo) lo = hist[k];
                    end
                    e_period[i] = n; e_max[i] = hi; e_min[i] = lo; e_amp[i] = hi - lo;
                    e_mv[i] = 1'b1; e_lk[i] = 1'b1;
                    win_start[i] = idx;
                end else if (n == (1 << pw_of[i]) - 1) begin
                    e_to[i] = 1'b1; e_lk[i] = 1'b0; m_run[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("p0.period", 32'(p0), e_period[0]);
        chk("p0.peak_max", 32'(mx0), e_max[0]);
        chk("p0.peak_min", 32'(mn0), e_min[0]);
        chk("p0.amplitude", 32'(amp0), e_amp[0]);
        chk("p0.meas_valid", 32'(mv0), 32'(e_mv[0]));
        chk("p0.timeout", 32'(to0), 32'(e_to[0]));
        chk("p0.locked", 32'(lk0), 32'(e_lk[0]));
        chk("p0.state", 32'(st0), 32'(m_run[0] ? S_RUN : S_ACQ));
        chk("p1.period", 32'(p1), e_period[1]);
        chk("p1.peak_max", 32'(mx1), e_max[1]);
        chk("p1.peak_min", 32'(mn1), e_min[1]);
        chk("p1.amplitude", 32'(amp1), e_amp[1]);
        chk("p1.meas_valid", 32'(mv1), 32'(e_mv[1]));
        chk("p1.timeout", 32'(to1), 32'(e_to[1]));
        chk("p1.locked", 32'(lk1), 32'(e_lk[1]));
        chk("p1.state", 32'(st1), 32'(m_run[1] ? S_RUN : S_ACQ));
    endtask

    // One clock: present inputs, advance model on the edge, compare 1 time unit later.
    task automatic step(input bit r, input bit v, input int s);
        rst = r;
        sample_valid = v;
        sample_in = sample_t'(s);
        @(posedge clk);
        model_clock(r, v, s);
        #1;
        check_all();
    endtask

    task automatic push(input int s, input bit gaps);
        step(1'b0, 1'b1, s);
        if (gaps) step(1'b0, 1'b0, int'($urandom_range(0, 255)));
    endtask

    task automatic square(input int hi_n, input int lo_n, input int reps, input bit gaps);
        for (int r = 0; r < reps; r++) begin
            for (int k = 0; k < hi_n; k++) push(200, gaps);
            for (int k = 0; k < lo_n; k++) push(50, gaps);
        end
    endtask

    int mv_gap;
    int last_mv;

    initial begin
        model_reset();
        @(negedge clk);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0);

        // Plain square wave, valid every cycle.
        square(4, 4, 6, 1'b0);
        chk("sq.period", 32'(p0), 8);
        chk("sq.peak_max", 32'(mx0), 200);
        chk("sq.peak_min", 32'(mn0), 50);
        chk("sq.amplitude", 32'(amp0), 150);
        chk("sq.locked", 32'(lk0), 1);

        // Same wave with a gap after every sample; strobes are 16 clocks apart.
        last_mv = -1;
        mv_gap = 0;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 8; k++) begin
                for (int g = 0; g < 2; g++) begin
                    step(1'b0, (g == 0), (g == 0) ? ((k < 4) ? 200 : 50) : 17);
                    if (mv0) begin
                        if (last_mv >= 0) mv_gap = (r * 16 + k * 2 + g) - last_mv;
                        last_mv = r * 16 + k * 2 + g;
                    end
                end
            end
        end
        chk("gap.strobe_spacing", 32'(mv_gap), 16);
        chk("gap.period", 32'(p0), 8);

        // Chatter inside the hysteresis band must not create extra edges.
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) push(200, 1'b0);
            for (int k = 0; k < 3; k++) push(100, 1'b0);
            for (int k = 0; k < 3; k++) push(130, 1'b0);
            for (int k = 0; k < 4; k++) push(50, 1'b0);
        end
        chk("chatter.period", 32'(p0), 14);
        chk("chatter.peak_min", 32'(mn0), 50);
        chk("chatter.peak_max", 32'(mx0), 200);

        // Reset mid-window while locked, then recovery takes two edges.
        square(4, 4, 2, 1'b0);
        push(200, 1'b0);
        push(200, 1'b0);
        step(1'b1, 1'b1, 200);
        chk("rst.locked", 32'(lk0), 0);
        chk("rst.period", 32'(p0), 0);
        square(4, 4, 3, 1'b0);

        // Window of exactly 15: the short instance's edge at the last count wins.
        square(7, 8, 3, 1'b0);
        chk("boundary.p1_period", 32'(p1), 15);

        // Constant high after an edge: the short instance times out.
        for (int k = 0; k < 20; k++) push(200, 1'b0);
        chk("timeout.p1_locked", 32'(lk1), 0);
        chk("timeout.p1_state", 32'(st1), 32'(S_ACQ));
        chk("timeout.p1_period_kept", 32'(p1), 15);

        // Full ramps.
        for (int r = 0; r < 3; r++)
            for (int s = 0; s < 256; s++) push(s, 1'b0);
        chk("ramp.period", 32'(p0), 256);
        chk("ramp.peak_min", 32'(mn0), 0);
        chk("ramp.peak_max", 32'(mx0), 255);
        chk("ramp.amplitude", 32'(amp0), 255);

        // Random stream with random gaps and occasional resets.
        for (int k = 0; k < 2000; k++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7),
                 int'($urandom_range(0, 255)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
